pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 133 +++++++++++++
 tb/tb_pwm_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of pwm_in in step ticks,
// publishing once per period with a one-cycle valid strobe and flagging stuck inputs.
module pwm_capture #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] high_count,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         stuck
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;

    logic         r_s1, r_s2, r_s3;
    state_t       r_state;
    logic [N-1:0] r_pcnt, r_hcnt;
    logic [N-1:0] r_high_count, r_period;
    logic         r_valid, r_stuck;

    logic         w_rise, w_fall;
    logic [N-1:0] w_pcnt_inc, w_hcnt_inc;
    logic [N-1:0] w_pcnt_load, w_hcnt_load;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // Saturating increments: a missing edge parks the counter at CNT_MAX.
    assign w_pcnt_inc  = (step && r_pcnt != CNT_MAX) ? r_pcnt + 1'b1 : r_pcnt;
    assign w_hcnt_inc  = (step && r_s2 && r_hcnt != CNT_MAX) ? r_hcnt + 1'b1 : r_hcnt;
    assign w_pcnt_load = {{(N-1){1'b0}}, step};
    assign w_hcnt_load = {{(N-1){1'b0}}, step & r_s2};

    // NOTE: s1/s2 form the metastability synchronizer; s3 only delays s2 so that
    // both edge detectors see the same latency. Runs regardless of ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // NOTE: state and counters use non-blocking assignments so every branch reads
    // the pre-edge values; publish therefore captures counts before the reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pcnt       <= '0;
            r_hcnt       <= '0;
            r_high_count <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!ena) begin
                r_state <= IDLE;
                r_pcnt  <= '0;
                r_hcnt  <= '0;
                r_stuck <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_pcnt  <= w_pcnt_load;
                            r_hcnt  <= w_hcnt_load;
                        end
                    end
                    HIGH, LOW: begin
                        if (r_state == LOW && w_rise) begin
                            r_high_count <= r_hcnt;
                            r_period     <= r_pcnt;
                            r_valid      <= 1'b1;
                            r_state      <= HIGH;
                            r_pcnt       <= w_pcnt_load;
                            r_hcnt       <= w_hcnt_load;
                        end else if (r_pcnt == CNT_MAX) begin
                            // Timeout: report as duty 0 or full duty depending on level.
                            r_high_count <= r_s2 ? CNT_MAX : '0;
                            r_period     <= CNT_MAX;
                            r_valid      <= 1'b1;
                            r_stuck      <= 1'b1;
                            r_state      <= STUCK;
                            r_pcnt       <= '0;
                            r_hcnt       <= '0;
                        end else begin
                            r_pcnt <= w_pcnt_inc;
                            r_hcnt <= w_hcnt_inc;
                            if (r_state == HIGH && w_fall) begin
                                r_state <= LOW;
                            end
                        end
                    end
                    STUCK: begin
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_stuck <= 1'b0;
                            r_pcnt  <= w_pcnt_load;
                            r_hcnt  <= w_hcnt_load;
                        end else if (w_fall) begin
                            r_state <= IDLE;
                            r_stuck <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign high_count = r_high_count;
    assign period     = r_period;
    assign valid      = r_valid;
    assign stuck      = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: cycle-stepped stimulus with hand-computed
// valid timing and measured values.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       step;
    logic       pwm_in;
    logic [7:0] high_count;
    logic [7:0] period;
    logic       valid;
    logic       stuck;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int ph, hi, lo, mode, sdiv;
    int nvalid, nwrong, dbl, dbl_all, vskip;
    int gap_min, gap_max, last_vcyc, first_vcyc;
    int exp_hc, exp_per;
    int last_hc, last_per;
    int s;
    logic prev_v = 1'b0;

    pwm_capture #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .step       (step),
        .pwm_in     (pwm_in),
        .high_count (high_count),
        .period     (period),
        .valid      (valid),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        if (mode == 0) pwm_in = (ph < hi);
        else if (mode == 1) pwm_in = 1'b0;
        else pwm_in = 1'b1;
        step = ((cyc % sdiv) == 0);
    endtask

    task automatic clr_mon();
        nvalid     = 0;
        nwrong     = 0;
        dbl        = 0;
        gap_min    = 1000000;
        gap_max    = 0;
        first_vcyc = -1;
    endtask

    // One clock: sample outputs 1ns after the edge, then drive the next inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            if (prev_v) begin
                dbl++;
                dbl_all++;
            end
            if (nvalid >= vskip && (high_count !== exp_hc[7:0] || period !== exp_per[7:0]))
                nwrong++;
            if (nvalid > 0) begin
                if (cyc - last_vcyc < gap_min) gap_min = cyc - last_vcyc;
                if (cyc - last_vcyc > gap_max) gap_max = cyc - last_vcyc;
            end else begin
                first_vcyc = cyc;
            end
            last_vcyc = cyc;
            last_hc   = int'(high_count);
            last_per  = int'(period);
            nvalid++;
        end
        prev_v = valid;
        if (hi + lo > 0) ph = (ph + 1) % (hi + lo);
        drive_inputs();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic start_pattern(input int h, input int l);
        hi   = h;
        lo   = l;
        mode = 0;
        ph   = 0;
        drive_inputs();
    endtask

    task automatic do_reset();
        mode = 1;
        rst  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clr_mon();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; step = 1'b1; pwm_in = 1'b0;
        hi = 20; lo = 80; mode = 1; sdiv = 1; ph = 0;
        dbl_all = 0; vskip = 0; exp_hc = 0; exp_per = 0;
        last_vcyc = 0; last_hc = 0; last_per = 0;
        clr_mon();

        // Reset state
        repeat (2) tick();
        check("rst_high_count", high_count, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        rst = 1'b0;

        // 1: 20 high / 80 low, step every clock
        clr_mon();
        exp_hc = 20; exp_per = 100; vskip = 0;
        s = cyc;
        start_pattern(20, 80);
        run_to(s + 510);
        check("t1_first_valid_latency", first_vcyc - s, 103);
        check("t1_valid_count", nvalid, 5);
        check("t1_wrong_values", nwrong, 0);
        check("t1_gap_min", gap_min, 100);
        check("t1_gap_max", gap_max, 100);
        check("t1_double_valid", dbl, 0);
        check("t1_stuck", stuck, 0);

        // 2: 40 high / 60 low, step every 4th clock; first result may be off by one
        do_reset();
        sdiv = 4;
        exp_hc = 10; exp_per = 25; vskip = 1;
        s = cyc;
        start_pattern(40, 60);
        run_to(s + 410);
        check("t2_valid_count", nvalid, 4);
        check("t2_wrong_values", nwrong, 0);
        check("t2_high_count", high_count, 10);
        check("t2_period", period, 25);

        // 3: input held low for 300 clocks after a valid period
        do_reset();
        sdiv = 1;
        s = cyc;
        start_pattern(20, 80);
        run_to(s + 230);
        check("t3_warmup_valids", nvalid, 2);
        mode = 1;
        drive_inputs();
        clr_mon();
        run_to(s + 530);
        check("t3_timeout_valids", nvalid, 1);
        check("t3_timeout_cycle", last_vcyc - s, 458);
        check("t3_high_count", last_hc, 0);
        check("t3_period", last_per, 255);
        check("t3_stuck_set", stuck, 1);
        start_pattern(20, 80);
        run_to(s + 540);
        check("t3_stuck_cleared", stuck, 0);
        check("t3_no_valid_on_rise", nvalid, 1);
        run_to(s + 640);
        check("t3_resume_valids", nvalid, 2);
        check("t3_resume_cycle", last_vcyc - s, 633);
        check("t3_resume_high", last_hc, 20);
        check("t3_resume_period", last_per, 100);

        // 4: input held high for 300 clocks
        mode = 2;
        drive_inputs();
        clr_mon();
        run_to(s + 940);
        check("t4_timeout_valids", nvalid, 1);
        check("t4_timeout_cycle", last_vcyc - s, 888);
        check("t4_high_count", last_hc, 255);
        check("t4_period", last_per, 255);
        check("t4_stuck_set", stuck, 1);
        mode = 1;
        drive_inputs();
        run_to(s + 950);
        check("t4_stuck_cleared_on_fall", stuck, 0);
        start_pattern(20, 80);
        clr_mon();
        run_to(s + 1050);
        check("t4_first_period_discarded", nvalid, 0);
        run_to(s + 1060);
        check("t4_second_period_valids", nvalid, 1);
        check("t4_second_period_cycle", last_vcyc - s, 1053);
        check("t4_second_high", last_hc, 20);
        check("t4_second_period", last_per, 100);

        // 5: ena dropped mid-HIGH for 10 clocks
        ena = 1'b0;
        clr_mon();
        run_to(s + 1070);
        check("t5_no_valid_disabled", nvalid, 0);
        check("t5_hold_high_count", high_count, 20);
        check("t5_hold_period", period, 100);
        check("t5_stuck_disabled", stuck, 0);
        ena = 1'b1;
        run_to(s + 1200);
        check("t5_first_period_discarded", nvalid, 0);
        run_to(s + 1260);
        check("t5_resume_valids", nvalid, 1);
        check("t5_resume_cycle", last_vcyc - s, 1253);
        check("t5_resume_high", last_hc, 20);
        check("t5_resume_period", last_per, 100);

        // 6: asynchronous reset pulse mid-LOW
        run_to(s + 1280);
        #2;
        rst = 1'b1;
        #1;
        clr_mon();
        check("t6_async_high_count", high_count, 0);
        check("t6_async_period", period, 0);
        check("t6_async_valid", valid, 0);
        check("t6_async_stuck", stuck, 0);
        tick();
        rst = 1'b0;
        run_to(s + 1400);
        check("t6_no_spurious_valid", nvalid, 0);
        run_to(s + 1460);
        check("t6_resume_valids", nvalid, 1);
        check("t6_resume_cycle", last_vcyc - s, 1453);
        check("t6_resume_high", last_hc, 20);
        check("t6_resume_period", last_per, 100);

        check("all_no_double_valid", dbl_all, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
